// File: rtl/mips_pkg.sv
// Shared MIPS constants and the fetch-buffer entry type.
package mips_pkg;

  localparam int unsigned     XLEN         = 32;
  localparam logic [XLEN-1:0] INSTR_STEP   = 32'd4;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus and the fetch-to-decode handshake.
interface pc_fetch_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} with occupancy count and flush.
// Storage is reset so the head reads as zero out of reset.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer, count and storage update; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign dout = mem[rd_ptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                    !(push && !pop && !clr && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                    !(pop && !clr && count == '0));

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests and buffers returned
// instructions for decode. Optional macro PC_FETCH_ALIGN_CHECK_EN enables the
// sticky misaligned-redirect flag and fetch halt.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_misalign,
  pc_fetch_if.master      bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned DW = 8;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [DW-1:0]   drop;
  logic [DW-1:0]   drop_next;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   pend_count;
  logic            halt;
  logic            issue;
  logic            keep;
  logic            pop;
  logic            credit_ok;
  logic            unused_bits;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_in;
  fetch_entry_t    pend_head;
  fetch_entry_t    pend_in;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic target_bad;
  assign target      = redirect_pc;
  assign target_bad  = |redirect_pc[1:0];
  assign unused_bits = ^pend_head.instr;

  // Misaligned redirect halts fetch until an aligned redirect; flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt           <= 1'b0;
      fetch_misalign <= 1'b0;
    end else if (redirect_valid) begin
      halt           <= target_bad;
      fetch_misalign <= fetch_misalign | target_bad;
    end
  end
`else
  assign target         = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits    = ^{pend_head.instr, redirect_pc[1:0]};
  assign halt           = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign pop   = (buf_count != '0) && bus.if_ready && !redirect_valid;
  assign keep  = bus.imem_rvalid && (drop == '0) && !redirect_valid;
  assign issue = bus.imem_req && bus.imem_gnt;

  // A pop this cycle frees a buffer slot, so it is credited here; this keeps
  // outstanding+count <= DEPTH while sustaining one fetch per cycle.
  assign credit_ok = ({1'b0, pend_count} + {1'b0, buf_count}) < (SW'(DEPTH) + SW'(pop));

  assign bus.imem_req  = !rst && !halt && !redirect_valid && credit_ok;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = (buf_count != '0);
  assign bus.if_pc     = buf_head.pc;
  assign bus.if_instr  = buf_head.instr;

  assign pend_in = '{pc: pc, instr: '0};
  assign buf_in  = '{pc: pend_head.pc, instr: bus.imem_rdata};

  // Program counter: redirect beats sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= target;
    else if (issue)          pc <= pc + INSTR_STEP;
  end

  // Responses still in flight at a redirect join any earlier pending drops.
  always_comb begin
    drop_next = drop;
    if (bus.imem_rvalid && drop != '0) drop_next = drop - DW'(1);
    if (redirect_valid)
      drop_next = drop_next + DW'(pend_count) - DW'(bus.imem_rvalid && drop == '0);
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop <= '0;
    else     drop <= drop_next;
  end

  // Pending-PC queue; its occupancy is the outstanding-request count.
  fetch_fifo #(.DEPTH(DEPTH)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (issue),
    .din   (pend_in),
    .pop   (keep),
    .dout  (pend_head),
    .count (pend_count)
  );

  // Instruction buffer feeding decode.
  fetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (keep),
    .din   (buf_in),
    .pop   (pop),
    .dout  (buf_head),
    .count (buf_count)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
                    bus.imem_rvalid |-> (drop != '0 || pend_count != '0));
  a_credit:       assert property (@(posedge clk) disable iff (rst)
                    ({1'b0, pend_count} + {1'b0, buf_count}) <= SW'(DEPTH));

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: table-driven cycle vectors plus redirect/wrap/misalign/
// reset sequences, with an in-order memory model and expected-delivery queue.
module tb_pc_fetch;
  import mips_pkg::*;

  logic        clk            = 1'b0;
  logic        rst            = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        fetch_misalign;

  pc_fetch_if bus();

  pc_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { int unsigned due; logic [31:0] addr; } rsp_t;
  typedef struct {
    logic        rst_before;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  exp_t        sb[$];
  rsp_t        mem_q[$];
  vec_t        vecs[13];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic [31:0] model_pc = '0;
  logic        halted = 1'b0;
  logic        exp_mis = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0F69;
  endfunction

  function automatic vec_t mk(input logic rb, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic v, input logic [31:0] pc);
    vec_t r;
    r.rst_before = rb; r.rdy = rdy; r.exp_req = req;
    r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
    sb.delete(); mem_q.delete();
    model_pc = 32'h0; halted = 1'b0; exp_mis = 1'b0;
    #1;
    chkb("rst_req", bus.imem_req, 1'b0);
    chkb("rst_valid", bus.if_valid, 1'b0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chkb("rst_misalign", fetch_misalign, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at negedge, observe 1 time unit later.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    exp_t e;
    @(negedge clk);
    redirect_valid = rv; redirect_pc = rpc; bus.if_ready = rdy; bus.imem_gnt = 1'b1;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    #1;
    if (rv) chkb("redirect_no_req", bus.imem_req, 1'b0);
    if (halted) chkb("halt_no_req", bus.imem_req, 1'b0);
    if (bus.imem_req && !rv && !halted) begin
      chk("req_addr", bus.imem_addr, model_pc);
      mem_q.push_back('{due: cyc + lat, addr: bus.imem_addr});
      sb.push_back('{pc: model_pc, instr: instr_of(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (bus.if_valid && rdy && !rv) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL deliver_unexpected: got pc %08h expected none (cycle %0d)", bus.if_pc, cyc);
      end else begin
        e = sb.pop_front();
        chk("deliver_pc", bus.if_pc, e.pc);
        chk("deliver_instr", bus.if_instr, e.instr);
      end
    end
    chkb("misalign", fetch_misalign, exp_mis);
    if (rv) begin
      sb.delete();
`ifdef PC_FETCH_ALIGN_CHECK_EN
      model_pc = rpc;
      halted   = (rpc[1:0] != 2'b00);
      if (halted) exp_mis = 1'b1;
`else
      model_pc = {rpc[31:2], 2'b00};
`endif
    end
    cyc++;
  endtask

  task automatic run_until_valid(input string name, input logic [31:0] exp_pc);
    int n = 0;
    do begin
      step(1'b0, '0, 1'b1);
      n++;
    end while (!bus.if_valid && n < 20);
    chkb({name, "_valid"}, bus.if_valid, 1'b1);
    if (bus.if_valid) chk({name, "_pc"}, bus.if_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;

    // Reset release with 1-cycle memory and ready decode, then stalled decode.
    vecs[0]  = mk(1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4);
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8);

    lat = 1;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst_before) do_reset();
      step(1'b0, '0, vecs[i].rdy);
      chkb($sformatf("vec%0d_req", i), bus.imem_req, vecs[i].exp_req);
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chkb($sformatf("vec%0d_valid", i), bus.if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_pc", i), bus.if_pc, vecs[i].exp_pc);
    end

    // Redirect with two 3-cycle requests in flight: both responses dropped.
    do_reset();
    lat = 3;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0000_0100, 1'b1);
    step(1'b0, '0, 1'b1);
    chkb("redir_next_req", bus.imem_req, 1'b1);
    chk("redir_next_addr", bus.imem_addr, 32'h0000_0100);
    run_until_valid("redir_first", 32'h0000_0100);
    lat = 1;

    // PC wraps from the top of the address space.
    do_reset();
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    run_until_valid("wrap_first", 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b1);
    chkb("wrap_second_valid", bus.if_valid, 1'b1);
    chk("wrap_second_pc", bus.if_pc, 32'h0000_0000);

    // Misaligned redirect target.
    do_reset();
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0000_0102, 1'b1);
    step(1'b0, '0, 1'b1);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chkb("mis_req", bus.imem_req, 1'b0);
    chkb("mis_flag", fetch_misalign, 1'b1);
`else
    chkb("mis_req", bus.imem_req, 1'b1);
    chk("mis_addr", bus.imem_addr, 32'h0000_0100);
    chkb("mis_flag", fetch_misalign, 1'b0);
`endif
    repeat (2) step(1'b0, '0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    step(1'b0, '0, 1'b1);
    chkb("resume_req", bus.imem_req, 1'b1);
    chk("resume_addr", bus.imem_addr, 32'h0000_0200);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chkb("resume_flag", fetch_misalign, 1'b1);
`else
    chkb("resume_flag", fetch_misalign, 1'b0);
`endif
    run_until_valid("resume", 32'h0000_0200);

    // Reset asserted with a full buffer.
    do_reset();
    repeat (4) step(1'b0, '0, 1'b0);
    chkb("full_valid", bus.if_valid, 1'b1);
    chk("full_head_pc", bus.if_pc, 32'h0);
    do_reset();
    step(1'b0, '0, 1'b1);
    chkb("post_rst_req", bus.imem_req, 1'b1);
    chk("post_rst_addr", bus.imem_addr, 32'h0000_0000);
    run_until_valid("post_rst", 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
